// File: rtl/arith_rr_sched4_if.sv
// rtl/arith_rr_sched4_if.sv - handshake bundle between requesters, scheduler and shared arithmetic unit
interface arith_rr_sched4_if;
    logic [3:0] req;
    logic       unit_done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       unit_start;
    logic [3:0] ack;
    logic       err;
    logic       busy;

    // scheduler side
    modport master (
        input  req,
        input  unit_done,
        output grant,
        output grant_idx,
        output unit_start,
        output ack,
        output err,
        output busy
    );

    // requester / shared-unit side
    modport slave (
        output req,
        output unit_done,
        input  grant,
        input  grant_idx,
        input  unit_start,
        input  ack,
        input  err,
        input  busy
    );
endinterface

// File: rtl/arith_rr_sched4.sv
// rtl/arith_rr_sched4.sv - round-robin scheduler sharing one multi-cycle arithmetic unit between four requesters
module arith_rr_sched4 #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    arith_rr_sched4_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Last WAIT count before abort; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       pick_idx;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    logic [3:0]       grant_q;
    logic [1:0]       idx_q;
    logic             start_q;
    logic [3:0]       ack_q;
    logic             err_q;
    logic             busy_q;

    // Rotating priority: scan offsets 4..1 so the smallest offset from ptr wins;
    // offset 4 wraps back onto ptr itself, giving it lowest priority.
    always_comb begin
        pick_idx = ptr;
        for (int i = 4; i >= 1; i--) begin
            if (bus.req[ptr + 2'(i)]) begin
                pick_idx = ptr + 2'(i);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Transaction sequencer: pick owner, pulse start, wait for done or timeout, ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= 2'd3;
            cnt     <= '0;
            grant_q <= 4'b0000;
            idx_q   <= 2'd0;
            start_q <= 1'b0;
            ack_q   <= 4'b0000;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req != 4'b0000) begin
                        idx_q   <= pick_idx;
                        grant_q <= 4'b0001 << pick_idx;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.unit_done) begin
                        ack_q <= grant_q;
                        err_q <= 1'b0;
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        ack_q <= grant_q;
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_q   <= 4'b0000;
                    err_q   <= 1'b0;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    ptr     <= idx_q;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_idx  = idx_q;
    assign bus.unit_start = start_q;
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_arith_rr_sched4.sv
// tb/tb_arith_rr_sched4.sv - self-checking bench for arith_rr_sched4
module tb_arith_rr_sched4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_drv = 4'b0000;
    logic       man_done = 1'b0;
    logic       auto_done = 1'b0;
    int         done_dly = -1;
    bit         rand_dly = 1'b0;
    int         ucnt = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    arith_rr_sched4_if bus ();

    assign bus.req       = req_drv;
    assign bus.unit_done = auto_done | man_done;

    arith_rr_sched4 #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shared-unit responder: pulses done a chosen number of cycles after each start.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (rst) begin
            ucnt = 0;
        end else begin
            if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) auto_done = 1'b1;
            end
            if (bus.unit_start) begin
                if (rand_dly) ucnt = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 10);
                else ucnt = (done_dly < 0) ? 0 : done_dly;
            end
        end
    end

    // Reference model: phase of the current transaction, its owner and age in cycles.
    int         m_phase = 0;
    int         m_owner = 0;
    int         m_last = 3;
    int         m_age = 0;
    logic [3:0] e_grant = 4'b0, e_ack = 4'b0;
    logic [1:0] e_idx = 2'd0;
    logic       e_start = 1'b0, e_err = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_last = 3;
            e_grant = 0; e_ack = 0; e_idx = 0; e_start = 0; e_err = 0; e_busy = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.req != 4'b0) begin
                        bit found;
                        found = 1'b0;
                        for (int k = 1; k <= 4; k++) begin
                            if (!found && bus.req[(m_last + k) % 4]) begin
                                m_owner = (m_last + k) % 4;
                                found = 1'b1;
                            end
                        end
                        m_phase = 1; m_age = 0;
                        e_grant = 4'(1 << m_owner); e_idx = 2'(m_owner);
                        e_start = 1; e_busy = 1;
                    end
                end
                1: begin
                    e_start = 0;
                    if (m_age >= 1 && bus.unit_done) begin
                        m_phase = 2; e_ack = e_grant; e_err = 0;
                    end else if (m_age >= 1 && TIMEOUT != 0 && m_age == TIMEOUT) begin
                        m_phase = 2; e_ack = e_grant; e_err = 1;
                    end
                    m_age++;
                end
                default: begin
                    m_last = m_owner; m_phase = 0;
                    e_ack = 0; e_err = 0; e_grant = 0; e_busy = 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("unit_start", 32'(bus.unit_start), 32'(e_start));
        chk("ack", 32'(bus.ack), 32'(e_ack));
        chk("err", 32'(bus.err), 32'(e_err));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        if (e_busy) chk("grant_idx", 32'(bus.grant_idx), 32'(e_idx));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_for(input string name, input bit on_ack, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 40) begin
            step();
            cyc++;
            hit = on_ack ? (bus.ack != 4'b0) : bus.unit_start;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s wait expired act=none exp=event", name);
        end
    endtask

    int         cyc;
    logic [3:0] gseq[5];
    logic [3:0] aseq[5];

    initial begin
        // reset state
        step();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        // single request, done 5 cycles after start
        do_reset();
        done_dly = 5;
        req_drv = 4'b0001;
        wait_for("t1_start", 1'b0, cyc);
        chk("t1_start_lat", 32'(cyc), 32'd1);
        chk("t1_grant", 32'(bus.grant), 32'h1);
        wait_for("t1_ack", 1'b1, cyc);
        chk("t1_ack_lat", 32'(cyc), 32'd6);
        chk("t1_ack", 32'(bus.ack), 32'h1);
        chk("t1_err", 32'(bus.err), 32'h0);
        req_drv = 4'b0000;
        step();
        chk("t1_grant_clr", 32'(bus.grant), 32'h0);

        // all four requesting, rotating service
        do_reset();
        done_dly = 3;
        req_drv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for("t2_start", 1'b0, cyc);
            gseq[k] = bus.grant;
            if (k == 4) req_drv = 4'b0000;
            wait_for("t2_ack", 1'b1, cyc);
            aseq[k] = bus.ack;
        end
        chk("t2_g0", 32'(gseq[0]), 32'h1);
        chk("t2_g1", 32'(gseq[1]), 32'h2);
        chk("t2_g2", 32'(gseq[2]), 32'h4);
        chk("t2_g3", 32'(gseq[3]), 32'h8);
        chk("t2_g4", 32'(gseq[4]), 32'h1);
        for (int k = 0; k < 5; k++) chk("t2_ack_match", 32'(aseq[k]), 32'(gseq[k]));
        step();

        // last served 1, then 0011 -> 0 wins, then 0010 -> 1
        do_reset();
        done_dly = 2;
        req_drv = 4'b0010;
        wait_for("t3_start_a", 1'b0, cyc);
        wait_for("t3_ack_a", 1'b1, cyc);
        req_drv = 4'b0011;
        wait_for("t3_start_b", 1'b0, cyc);
        chk("t3_grant_b", 32'(bus.grant), 32'h1);
        wait_for("t3_ack_b", 1'b1, cyc);
        req_drv = 4'b0010;
        wait_for("t3_start_c", 1'b0, cyc);
        chk("t3_grant_c", 32'(bus.grant), 32'h2);
        chk("t3_idx_c", 32'(bus.grant_idx), 32'h1);
        wait_for("t3_ack_c", 1'b1, cyc);
        req_drv = 4'b0000;
        step();

        // timeout: unit never answers
        do_reset();
        done_dly = -1;
        req_drv = 4'b0100;
        wait_for("t4_start", 1'b0, cyc);
        wait_for("t4_ack", 1'b1, cyc);
        chk("t4_ack_lat", 32'(cyc), 32'd9);
        chk("t4_ack", 32'(bus.ack), 32'h4);
        chk("t4_err", 32'(bus.err), 32'h1);
        req_drv = 4'b0000;
        step();
        chk("t4_idle", 32'(bus.busy), 32'h0);

        // stray done while idle, owner drops req mid-wait
        do_reset();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("t5_no_ack", 32'(bus.ack), 32'h0);
        chk("t5_no_busy", 32'(bus.busy), 32'h0);
        done_dly = 6;
        req_drv = 4'b0001;
        wait_for("t5_start", 1'b0, cyc);
        step();
        step();
        req_drv = 4'b0000;
        wait_for("t5_ack", 1'b1, cyc);
        chk("t5_ack_lat", 32'(cyc), 32'd5);
        chk("t5_ack", 32'(bus.ack), 32'h1);
        step();

        // reset during wait, then fresh service from ptr=3
        do_reset();
        done_dly = -1;
        req_drv = 4'b0010;
        wait_for("t6_start", 1'b0, cyc);
        step();
        step();
        step();
        rst = 1'b1;
        req_drv = 4'b0000;
        step();
        chk("t6_grant", 32'(bus.grant), 32'h0);
        chk("t6_busy", 32'(bus.busy), 32'h0);
        chk("t6_ack", 32'(bus.ack), 32'h0);
        rst = 1'b0;
        done_dly = 2;
        req_drv = 4'b1000;
        wait_for("t6_start2", 1'b0, cyc);
        chk("t6_start2_lat", 32'(cyc), 32'd1);
        chk("t6_grant2", 32'(bus.grant), 32'h8);
        wait_for("t6_ack2", 1'b1, cyc);
        chk("t6_ack2", 32'(bus.ack), 32'h8);
        req_drv = 4'b0000;
        step();

        // randomized traffic against the model
        rand_dly = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) req_drv[i] = 1'b0;
                else if (!req_drv[i] && ($urandom % 6 == 0)) req_drv[i] = 1'b1;
                else if (req_drv[i] && bus.grant[i] && ($urandom % 40 == 0)) req_drv[i] = 1'b0;
            end
            man_done = ($urandom % 25 == 0);
            rst = ($urandom % 400 == 0);
            step();
        end
        man_done = 1'b0;
        rst = 1'b0;
        req_drv = 4'b0000;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arith_rr_sched4.md
Name: arith_rr_sched4

Overview:
- Round-robin scheduler that shares one multi-cycle arithmetic unit (multiplier / root unit class) between four requesters.
- Picks a requester and holds a one-hot grant plus a binary index for the operand/result muxes.
- Pulses the unit's start, waits for its done, then returns a per-requester ack.
- Sits between the requester FSMs and the shared unit in the arithmetics datapath.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  request per requester; level, held until ack
- unit_done  in  1  one-cycle pulse from the shared unit when its result is valid
- grant  out  4  one-hot owner of the unit; 4'b0000 when idle
- grant_idx  out  2  binary index of the owner; drives the operand/result mux select
- unit_start  out  1  one-cycle start pulse to the shared unit
- ack  out  4  one-hot, one-cycle completion pulse to the owner
- err  out  1  one-cycle pulse, coincident with ack, when the transaction timed out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- All outputs registered. Reset values: grant=0, grant_idx=0, unit_start=0, ack=0, err=0, busy=0, state=IDLE, ptr=3, cnt=0.
- ptr (2 bits) holds the last served index. Priority search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4 (wrap 3->0). After reset, requester 0 has top priority.
- IDLE:
  - If req==0, stay.
  - Otherwise select the first set req bit in priority order. Load grant_idx and grant (grant = 2-to-4 decode of grant_idx). Go to START.
- START:
  - unit_start=1 for exactly this cycle; grant held; cnt cleared.
  - Always go to WAIT.
- WAIT:
  - unit_start=0; cnt increments each cycle.
  - If unit_done=1, go to DONE with err flag clear.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1, go to DONE with err flag set.
  - unit_done and the timeout in the same cycle: done wins, err=0.
- DONE:
  - ack[grant_idx]=1 and err=flag for exactly this cycle.
  - ptr<=grant_idx.
  - grant clears at the end of this cycle. Go to IDLE.
- grant and grant_idx are stable from the START cycle through the DONE cycle inclusive. busy=1 over the same span.
- Latency:
  - req seen in IDLE at edge t gives grant/unit_start visible in cycle t+1.
  - unit_done in cycle d gives ack in cycle d+1 and IDLE in cycle d+2.
  - A still-pending request is granted in cycle d+3 at the earliest.
- Ignored inputs:
  - unit_done outside WAIT is ignored (no ack, no state change).
  - req changes after grant, including the owner dropping its req, do not abort; the transaction completes and ack still pulses.
- Requester rule: drop req in the cycle after ack. A req still high after ack is re-arbitrated at lowest priority, because ptr now points at it.
- Reset mid-operation (any state): next cycle all outputs and ptr return to reset values. No ack or err is emitted for the aborted transaction.
- Invariants: grant has at most one bit set. ack has at most one bit set. ack is only ever the bit equal to the grant that was held.

Test Plan:
- Reset, then req=4'b0001, unit_done pulsed 5 cycles after unit_start -> grant=0001 and unit_start=1 in the cycle after req; ack=0001 in the cycle after unit_done; err=0; grant=0 after.
- req=4'b1111 held, each done answered 3 cycles after start -> grant sequence 0001, 0010, 0100, 1000, 0001; exactly one ack per grant in matching order.
- ptr=1 (last served 1), req=4'b0011 -> grant=0100? no, 0100 not requested, so grant=0001 (search 2,3,0); then with req=4'b0010 only -> grant=0010.
- TIMEOUT=8, grant taken, unit_done never pulsed -> ack and err both pulse 1 cycle, 9 cycles after unit_start; FSM back to IDLE.
- unit_done pulsed while IDLE, and owner drops req mid-WAIT -> no spurious ack; the in-flight transaction still acks on its real unit_done.
- rst asserted during WAIT -> next cycle grant=0, busy=0, no ack; with req=4'b1000 afterwards, service proceeds normally with ptr reset to 3.
